// File: rtl/keypad_multitap.sv
// keypad_multitap: 4x3 matrix keypad scanner with debounce and phone-style
// multi-tap letter entry. '*' commits the pending letter, '#' submits a word.
// Optional feature macro: KEYPAD_TAP_TIMEOUT_EN (locks a pending multi-tap
// letter after TAP_TIMEOUT idle cycles so the next same-key tap starts anew).
module keypad_multitap #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 2000,
  parameter int TAP_TIMEOUT     = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [2:0] cols,
  output logic [7:0] letter,
  output logic       letter_pending,
  output logic       letter_strobe,
  output logic [7:0] letter_out,
  output logic       word_strobe,
  output logic       key_event
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t        state_reg;
  logic [3:0]    rs_meta_reg, rs_reg;
  logic [2:0]    cols_reg, cols_d1_reg, cols_d2_reg;
  logic [SW-1:0] div_cnt_reg;
  logic [DW-1:0] deb_cnt_reg;
  logic [3:0]    key_row_reg;
  logic [2:0]    key_col_reg;
  logic          key_event_reg, letter_strobe_reg, word_strobe_reg;
  logic [7:0]    letter_out_reg, letter_reg;
  logic          pending_reg;
  logic [3:0]    last_key_reg;
  logic [1:0]    idx_reg;
  logic          locked;

  // Map a latched {row, col} pair to a key code: 0..9 digits, 10='*', 11='#'.
  function automatic logic [3:0] key_code(input logic [3:0] r, input logic [2:0] c);
    logic [3:0] ri, ci;
    case (r)
      4'b1000: ri = 4'd0;
      4'b0100: ri = 4'd1;
      4'b0010: ri = 4'd2;
      default: ri = 4'd3;
    endcase
    case (c)
      3'b001:  ci = 4'd0;
      3'b010:  ci = 4'd1;
      default: ci = 4'd2;
    endcase
    if (ri != 4'd3)
      key_code = ri * 4'd3 + ci + 4'd1;
    else if (ci == 4'd0)
      key_code = KEY_STAR;
    else if (ci == 4'd1)
      key_code = 4'd0;
    else
      key_code = KEY_HASH;
  endfunction

  // First letter of each digit's multi-tap group.
  function automatic logic [7:0] base_letter(input logic [3:0] k);
    case (k)
      4'd2:    base_letter = 8'h41;
      4'd3:    base_letter = 8'h44;
      4'd4:    base_letter = 8'h47;
      4'd5:    base_letter = 8'h4A;
      4'd6:    base_letter = 8'h4D;
      4'd7:    base_letter = 8'h50;
      4'd8:    base_letter = 8'h54;
      4'd9:    base_letter = 8'h57;
      default: base_letter = 8'h00;
    endcase
  endfunction

  logic       rs_onehot;
  logic [3:0] press_code;
  logic       is_letter_key, same_key;
  logic [1:0] idx_next;

  assign rs_onehot  = (rs_reg != 4'd0) && ((rs_reg & (rs_reg - 4'd1)) == 4'd0);
  // key_row/key_col stay latched through HELD, so the code is still valid
  // in the cycle after key_event when the letter state is updated.
  assign press_code = key_code(key_row_reg, key_col_reg);

  // Next tap index: cycle within the group on repeat taps, else restart at 0.
  always_comb begin
    is_letter_key = (press_code >= 4'd2) && (press_code <= 4'd9);
    same_key      = is_letter_key && pending_reg && !locked && (last_key_reg == press_code);
    idx_next      = 2'd0;
    if (same_key) begin
      if ((press_code == 4'd7) || (press_code == 4'd9))
        idx_next = idx_reg + 2'd1;
      else
        idx_next = (idx_reg == 2'd2) ? 2'd0 : idx_reg + 2'd1;
    end
  end

  // Two-flop row synchronizer plus a matching delay of the column drive so
  // a synchronized row is always paired with the column that produced it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_meta_reg <= 4'd0;
      rs_reg      <= 4'd0;
      cols_d1_reg <= 3'b001;
      cols_d2_reg <= 3'b001;
    end else begin
      rs_meta_reg <= row;
      rs_reg      <= rs_meta_reg;
      cols_d1_reg <= cols_reg;
      cols_d2_reg <= cols_d1_reg;
    end
  end

  // Scan / debounce FSM with registered event and strobe outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= SCAN;
      cols_reg          <= 3'b001;
      div_cnt_reg       <= '0;
      deb_cnt_reg       <= '0;
      key_row_reg       <= 4'd0;
      key_col_reg       <= 3'b001;
      key_event_reg     <= 1'b0;
      letter_strobe_reg <= 1'b0;
      word_strobe_reg   <= 1'b0;
      letter_out_reg    <= 8'h00;
    end else begin
      key_event_reg     <= 1'b0;
      letter_strobe_reg <= 1'b0;
      word_strobe_reg   <= 1'b0;
      case (state_reg)
        SCAN: begin
          if (rs_onehot && (cols_d2_reg == cols_reg)) begin
            key_row_reg <= rs_reg;
            key_col_reg <= cols_reg;
            deb_cnt_reg <= '0;
            div_cnt_reg <= '0;
            state_reg   <= DEBOUNCE;
          end else if (div_cnt_reg == SW'(SCAN_DIV - 1)) begin
            div_cnt_reg <= '0;
            cols_reg    <= {cols_reg[1:0], cols_reg[2]};
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (rs_reg != key_row_reg) begin
            state_reg <= SCAN;
          end else if (deb_cnt_reg == DW'(DEBOUNCE_CYCLES - 1)) begin
            key_event_reg <= 1'b1;
            if ((press_code == KEY_STAR) && pending_reg) begin
              letter_strobe_reg <= 1'b1;
              letter_out_reg    <= letter_reg;
            end
            word_strobe_reg <= (press_code == KEY_HASH);
            state_reg       <= HELD;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + 1'b1;
          end
        end
        HELD: begin
          if (rs_reg == 4'd0) begin
            deb_cnt_reg <= '0;
            state_reg   <= RELEASE;
          end
        end
        RELEASE: begin
          if (rs_reg != 4'd0) begin
            state_reg <= HELD;
          end else if (deb_cnt_reg == DW'(DEBOUNCE_CYCLES - 1)) begin
            div_cnt_reg <= '0;
            state_reg   <= SCAN;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= SCAN;
      endcase
    end
  end

  // Multi-tap letter state, applied the cycle after key_event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      letter_reg   <= 8'h00;
      pending_reg  <= 1'b0;
      last_key_reg <= 4'd0;
      idx_reg      <= 2'd0;
    end else if (key_event_reg) begin
      if (is_letter_key) begin
        last_key_reg <= press_code;
        idx_reg      <= idx_next;
        letter_reg   <= base_letter(press_code) + {6'd0, idx_next};
        pending_reg  <= 1'b1;
      end else if ((press_code != KEY_STAR) || pending_reg) begin
        letter_reg   <= 8'h00;
        pending_reg  <= 1'b0;
        last_key_reg <= 4'd0;
        idx_reg      <= 2'd0;
      end
    end
  end

`ifdef KEYPAD_TAP_TIMEOUT_EN
  localparam int TW = $clog2(TAP_TIMEOUT + 1);
  logic [TW-1:0] idle_cnt_reg;
  logic          locked_reg;

  // Idle timer: locks a pending letter once no press arrives for TAP_TIMEOUT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_reg <= '0;
      locked_reg   <= 1'b0;
    end else if (key_event_reg) begin
      idle_cnt_reg <= '0;
      locked_reg   <= 1'b0;
    end else if (pending_reg && !locked_reg) begin
      if (idle_cnt_reg == TW'(TAP_TIMEOUT - 1))
        locked_reg <= 1'b1;
      else
        idle_cnt_reg <= idle_cnt_reg + 1'b1;
    end
  end

  assign locked = locked_reg;
`else
  assign locked = 1'b0;
`endif

  assign cols           = cols_reg;
  assign letter         = letter_reg;
  assign letter_pending = pending_reg;
  assign letter_strobe  = letter_strobe_reg;
  assign letter_out     = letter_out_reg;
  assign word_strobe    = word_strobe_reg;
  assign key_event      = key_event_reg;

endmodule

// File: tb/tb_keypad_multitap.sv
// Scoreboard bench for keypad_multitap: a keypad model drives rows from the
// DUT's column drive; each press pushes the expected event to a queue that a
// monitor pops whenever key_event or a strobe is seen.
module tb_keypad_multitap;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int TAP_TO   = 200;

  logic       tb_clk = 1'b0;
  logic       rst    = 1'b1;
  logic [3:0] row;
  logic [2:0] cols;
  logic [7:0] letter, letter_out;
  logic       letter_pending, letter_strobe, word_strobe, key_event;

  logic       key_down  = 1'b0;
  logic [1:0] key_r     = 2'd0;
  logic [1:0] key_c     = 2'd0;
  logic       force_en  = 1'b0;
  logic [3:0] force_val = 4'd0;

  int n_checks = 0;
  int n_fail   = 0;
  int ev_count = 0;

  typedef struct {
    bit         ls;
    bit         ws;
    logic [7:0] val;
  } exp_t;
  exp_t exp_q[$];

  // bench-side multi-tap model
  logic [7:0] m_letter  = 8'h00;
  logic       m_pending = 1'b0;
  int         m_last    = -1;
  int         m_idx     = 0;
  bit         m_locked  = 1'b0;

  always #5 tb_clk = ~tb_clk;

  assign row = force_en ? force_val :
               (key_down && cols[key_c]) ? (4'b1000 >> key_r) : 4'b0000;

  keypad_multitap #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB), .TAP_TIMEOUT(TAP_TO)
  ) dut (
    .clk(tb_clk), .rst(rst), .row(row), .cols(cols), .letter(letter),
    .letter_pending(letter_pending), .letter_strobe(letter_strobe),
    .letter_out(letter_out), .word_strobe(word_strobe), .key_event(key_event)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: every event or strobe cycle consumes one scoreboard entry.
  always @(negedge tb_clk) begin
    if (!rst && (key_event || letter_strobe || word_strobe)) begin
      ev_count++;
      if (exp_q.size() == 0) begin
        check("spurious_event", {29'd0, key_event, letter_strobe, word_strobe}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event_flags", {29'd0, key_event, letter_strobe, word_strobe},
              {29'd0, 1'b1, e.ls, e.ws});
        if (e.ls) check("letter_out", {24'd0, letter_out}, {24'd0, e.val});
        $display("event: ke=%0b ls=%0b ws=%0b letter_out=%02h", key_event,
                 letter_strobe, word_strobe, letter_out);
      end
    end
  end

  // Press and release one key: code 0..9 digits, 10='*', 11='#'.
  task automatic press(input int d);
    exp_t       e;
    logic [7:0] prev, nl;
    logic       np;
    int         nidx, nlast, gsize, off;
    bit         seen;
    prev  = m_letter;
    nl    = m_letter;
    np    = m_pending;
    nidx  = m_idx;
    nlast = m_last;
    e.ls  = 1'b0;
    e.ws  = 1'b0;
    e.val = 8'h00;
    if (d >= 2 && d <= 9) begin
      gsize = (d == 7 || d == 9) ? 4 : 3;
      off   = 3 * (d - 2) + ((d > 7) ? 1 : 0);
      if (m_pending && m_last == d && !m_locked) nidx = (m_idx + 1) % gsize;
      else nidx = 0;
      nlast = d;
      nl    = 8'h41 + 8'(off + nidx);
      np    = 1'b1;
    end else if (d == 10) begin
      if (m_pending) begin
        e.ls = 1'b1; e.val = m_letter;
        nl = 8'h00; np = 1'b0; nlast = -1; nidx = 0;
      end
    end else begin
      e.ws = (d == 11);
      nl = 8'h00; np = 1'b0; nlast = -1; nidx = 0;
    end
    exp_q.push_back(e);
    if (d == 0)       begin key_r = 2'd3; key_c = 2'd1; end
    else if (d == 10) begin key_r = 2'd3; key_c = 2'd0; end
    else if (d == 11) begin key_r = 2'd3; key_c = 2'd2; end
    else              begin key_r = 2'((d - 1) / 3); key_c = 2'((d - 1) % 3); end
    key_down = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge tb_clk);
      if (key_event) seen = 1'b1;
    end
    if (!seen) check("press_timeout", {31'd0, key_event}, 32'd1);
    else       check("letter_hold", {24'd0, letter}, {24'd0, prev});
    m_letter = nl; m_pending = np; m_idx = nidx; m_last = nlast; m_locked = 1'b0;
    @(negedge tb_clk);
    check("letter", {24'd0, letter}, {24'd0, m_letter});
    check("pending", {31'd0, letter_pending}, {31'd0, m_pending});
    $display("press key %0d: letter=%02h pending=%0b", d, letter, letter_pending);
    key_down = 1'b0;
    repeat (2 * DEB + 6) @(negedge tb_clk);
  endtask

  initial begin
    int ev_before;
    repeat (3) @(negedge tb_clk);
    rst = 1'b0;
    @(negedge tb_clk);
    check("rst_cols", {29'd0, cols}, 32'b001);
    check("rst_letter", {24'd0, letter}, 32'd0);
    check("rst_pending", {31'd0, letter_pending}, 32'd0);
    check("rst_strobes", {29'd0, key_event, letter_strobe, word_strobe}, 32'd0);
    check("rst_letter_out", {24'd0, letter_out}, 32'd0);
    repeat (5) @(negedge tb_clk);

    press(2); press(10);                       // A, commit A
    press(5); press(5); press(5); press(10);   // J K L, commit L
    for (int i = 0; i < 5; i++) press(7);      // P Q R S P
    press(3);                                  // D with index reset
    press(1);                                  // discard
    press(3); press(3);                        // D E
    press(11);                                 // word, discard E
    press(10);                                 // '*' with nothing pending
    press(4); press(0);                        // G then discard via '0'
    press(9); press(9); press(9); press(9); press(9); press(10); // W X Y Z W, commit W

    // Short press: one-hot row for half the debounce time.
    ev_before = ev_count;
    force_val = 4'b1000; force_en = 1'b1;
    repeat (DEB / 2) @(negedge tb_clk);
    force_en = 1'b0;
    repeat (30) @(negedge tb_clk);
    check("short_press_no_event", ev_count, ev_before);
    check("short_press_letter", {24'd0, letter}, {24'd0, m_letter});

    // Two rows at once are never accepted.
    force_val = 4'b1100; force_en = 1'b1;
    repeat (60) @(negedge tb_clk);
    force_en = 1'b0;
    repeat (30) @(negedge tb_clk);
    check("multi_row_no_event", ev_count, ev_before);

    // Reset in the middle of a debounce with a letter pending.
    press(2);
    force_val = 4'b0100; force_en = 1'b1;
    repeat (5) @(negedge tb_clk);
    rst = 1'b1;
    #1;
    check("mid_rst_cols", {29'd0, cols}, 32'b001);
    check("mid_rst_letter", {24'd0, letter}, 32'd0);
    check("mid_rst_pending", {31'd0, letter_pending}, 32'd0);
    check("mid_rst_letter_out", {24'd0, letter_out}, 32'd0);
    check("mid_rst_strobes", {29'd0, key_event, letter_strobe, word_strobe}, 32'd0);
    force_en = 1'b0;
    m_letter = 8'h00; m_pending = 1'b0; m_last = -1; m_idx = 0;
    @(negedge tb_clk);
    rst = 1'b0;
    repeat (10) @(negedge tb_clk);
    check("post_rst_no_event", ev_count, ev_before + 1);

`ifdef KEYPAD_TAP_TIMEOUT_EN
    press(2);
    repeat (TAP_TO + 10) @(negedge tb_clk);
    m_locked = 1'b1;
    press(2);                                  // new 'A', not 'B'
    check("timeout_pending", {31'd0, letter_pending}, 32'd1);
    press(10);                                 // commit the fresh 'A'
`else
    press(2);
    repeat (TAP_TO + 10) @(negedge tb_clk);
    press(2);                                  // no timeout: cycles to 'B'
    press(10);
`endif

    repeat (10) @(negedge tb_clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/keypad_multitap.md
# keypad_multitap

Keypad front end for the hangman host and player consoles. It scans the 4x3 matrix keypad and debounces key presses. Phone-style multi-tap presses become a pending ASCII letter, which is committed to the game logic by the submit-letter key. A separate submit-word key produces its own command pulse. One instance sits directly upstream of each console's game/message logic in `main` and consumes that console's raw `row` input.

## Interface
Parameters:
- `SCAN_DIV`, 1000: clock cycles each column is driven during scanning.
- `DEBOUNCE_CYCLES`, 2000: consecutive stable cycles needed to accept a press or a release.
- `TAP_TIMEOUT`, 100000: idle cycles after which a multi-tap sequence locks. Used only with `KEYPAD_TAP_TIMEOUT_EN`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous active-high reset.
- `row`, in, 4: keypad rows, active-high and asynchronous.
  - `row[3]`=R0 (keys 1 2 3), `row[2]`=R1 (4 5 6), `row[1]`=R2 (7 8 9), `row[0]`=R3 (* 0 #).
- `cols`, out, 3: one-hot column drive; `cols[0]`=C0, `cols[2]`=C2.
- `letter`, out, 8: pending ASCII letter; 8'h00 when none is pending.
- `letter_pending`, out, 1: high while `letter` holds an uncommitted letter.
- `letter_strobe`, out, 1: one-cycle pulse that commits `letter_out`.
- `letter_out`, out, 8: committed letter; valid only while `letter_strobe` is high.
- `word_strobe`, out, 1: one-cycle pulse for submit-word.
- `key_event`, out, 1: one-cycle pulse on every accepted press (debug/LED).

## Operation
- `row` passes through a 2-flop synchronizer; every decision below uses the synchronized value `rs`.
- Scan FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - `cols` rotates 001→010→100→001 every `SCAN_DIV` cycles.
  - If `rs` is one-hot, latch the key {row, col}, freeze `cols`, clear the counter and go to DEBOUNCE.
  - If `rs` is zero or has more than one bit set, keep scanning; multi-row patterns are never accepted.
- DEBOUNCE:
  - While `rs` equals the latched row, the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES`-1, pulse `key_event` and the press action, then go to HELD.
  - Any change in `rs` returns the FSM to SCAN with no event.
- HELD: wait for `rs`==0, then clear the counter and go to RELEASE. There is no auto-repeat.
- RELEASE:
  - After `DEBOUNCE_CYCLES` consecutive cycles of zero, go to SCAN.
  - Any nonzero `rs` returns the FSM to HELD.
- Key map:
  - R0: C0='1', C1='2', C2='3'.
  - R1: C0='4', C1='5', C2='6'.
  - R2: C0='7', C1='8', C2='9'.
  - R3: C0='*' (submit letter), C1='0', C2='#' (submit word).
- Letter groups: 2=ABC, 3=DEF, 4=GHI, 5=JKL, 6=MNO, 7=PQRS, 8=TUV, 9=WXYZ.
  - Group size is 4 for keys 7 and 9, otherwise 3.
- Press actions:
  - Letter key, same as the last letter key and `letter_pending`=1: tap index increments mod group size; `letter` = base + index.
  - Letter key, otherwise: record the key, set index 0, `letter` = base letter, `letter_pending`=1.
  - '*' with a letter pending: `letter_strobe`=1 and `letter_out`=`letter`; then clear `letter`, `letter_pending` and the last-key register.
  - '*' with nothing pending: no action.
  - '#': `word_strobe`=1; any pending letter is discarded without a strobe.
  - '1' and '0': the pending letter is discarded, with no strobe.
- Reset (asynchronous, at any point including mid-debounce):
  - FSM returns to SCAN with `cols`=3'b001.
  - All counters and the index go to 0.
  - `letter`=8'h00, `letter_out`=8'h00, `letter_pending`=0.
  - All strobes and `key_event` = 0.

## Timing
- Press latency:
  - Sync delay: 2 cycles.
  - Wait for the matching column: ≤3·`SCAN_DIV` cycles.
  - Debounce: `DEBOUNCE_CYCLES` cycles.
- `key_event`, `letter_strobe` and `word_strobe` are registered and assert in the same cycle.
- `letter` and `letter_pending` update on the clock edge that ends the `key_event` cycle.
- Only one action happens per accepted press, and at most one strobe is high in any cycle.
- A new press is accepted only after a full release debounce. Back-to-back taps therefore need `DEBOUNCE_CYCLES` cycles of release.
- A press shorter than `DEBOUNCE_CYCLES` produces no event and no output change.

## Configuration
- `KEYPAD_TAP_TIMEOUT_EN` defined:
  - An idle counter restarts on every accepted press.
  - When it reaches `TAP_TIMEOUT`, the pending letter locks: it stays pending, but the next press of the same key starts a new letter at index 0, replacing the locked one.
  - '*' still commits a locked letter.
- `KEYPAD_TAP_TIMEOUT_EN` not defined: there is no timeout, and repeated same-key taps always cycle the letter.

## Test plan
- Key '2' tap, then '*' → `letter` 8'h41 pending; then one `letter_strobe` with `letter_out`=8'h41 and `letter_pending` cleared.
- Key '5' ×3, then '*' → `letter` shows 8'h4A, 8'h4B, 8'h4C in turn; then a strobe with 8'h4C ('L').
- Key '7' ×5 → sequence P,Q,R,S,P (8'h50 after wrap); key '3' next → `letter` becomes 8'h44 ('D') with index reset.
- '3' ×2 pending ('E'), then '#' → `word_strobe` for exactly one cycle, no `letter_strobe`, and `letter`=8'h00.
- Bounce cases:
  - Rows 4'b1000 for `DEBOUNCE_CYCLES`/2 cycles → no `key_event`.
  - Rows 4'b1100 held → no event.
  - `rst` asserted mid-DEBOUNCE → `cols`=3'b001 and all outputs at reset values immediately.
- With `KEYPAD_TAP_TIMEOUT_EN`: '2', wait `TAP_TIMEOUT`+10 cycles, '2' → `letter` stays 8'h41 (new letter) rather than 8'h42.
